// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned IMEM_WORD_BYTES  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush. Used for the fetch buffer and the in-flight PC queue.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues in-order imem requests, buffers returned words
// for ID, and discards responses still in flight across an EX redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);
    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;
    logic          halted_q, halted_d, fpend_q, fpend_d;

    logic [CW-1:0] buf_count, pcq_count;
    logic          buf_full, buf_empty, pcq_full, pcq_empty;
    fetch_entry_t  buf_din, buf_dout;
    logic [31:0]   rsp_pc;
    logic          req_fire, rsp_keep, buf_push, buf_pop;
    logic [CW:0]   inflight;
    logic          unused_fifo_flags;

    assign inflight       = {1'b0, out_q} + {1'b0, drop_q} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !redirect_valid && !halted_q && (inflight < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0);

    assign if_valid = (!buf_empty || fpend_q) && !redirect_valid;
    assign if_fault = if_valid && fpend_q;
    assign if_pc    = fpend_q ? pc_q : buf_dout.pc;
    assign if_instr = fpend_q ? NOP_INSTR : buf_dout.instr;

    assign buf_push = rsp_keep && !redirect_valid;
    assign buf_pop  = if_valid && id_ready && !fpend_q;
    assign buf_din  = '{pc: rsp_pc, instr: imem_rsp_data};

    assign unused_fifo_flags = ^{buf_full, pcq_full, pcq_empty, pcq_count};

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect_valid),
        .din   (buf_din),
        .dout  (buf_dout),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Not flushed on redirect: discarded responses still consume their PC entry.
    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .din   (pc_q),
        .dout  (rsp_pc),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        halted_d = halted_q;
        fpend_d  = fpend_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            out_d    = '0;
            drop_d   = drop_q + out_q - CW'(imem_rsp_valid);
            halted_d = (redirect_pc[1:0] != 2'b00);
            fpend_d  = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (req_fire) pc_d = pc_q + 32'(IMEM_WORD_BYTES);
            if (imem_rsp_valid && !rsp_keep) drop_d = drop_q - 1'b1;
            out_d = out_q + CW'(req_fire) - CW'(rsp_keep);
            if (if_valid && id_ready) fpend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            halted_q <= 1'b0;
            fpend_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            halted_q <= halted_d;
            fpend_q  <= fpend_d;
        end
    end

endmodule
